// File: rtl/mcu_playlist_pkg.sv
// Shared encodings for the music-player playlist controller.
// Holds the FSM state codes, the end-of-song mode codes and the mode-cycling rule.
package mcu_playlist_pkg;

  typedef enum logic [1:0] {
    PAUSED  = 2'b00,
    PLAYING = 2'b01,
    SWITCH  = 2'b10
  } state_e;

  localparam logic [1:0] MODE_SINGLE     = 2'd0;
  localparam logic [1:0] MODE_REPEAT_ONE = 2'd1;
  localparam logic [1:0] MODE_CONTINUOUS = 2'd2;

  // The stray code 3 falls back to SINGLE, so the next press lands on SINGLE too.
  function automatic logic [1:0] next_mode(input logic [1:0] m);
    case (m)
      MODE_SINGLE:     next_mode = MODE_REPEAT_ONE;
      MODE_REPEAT_ONE: next_mode = MODE_CONTINUOUS;
      default:         next_mode = MODE_SINGLE;
    endcase
  endfunction

endpackage

// File: rtl/dffre.sv
// Register with asynchronous active-high reset and synchronous load enable.
module dffre #(
  parameter int           W       = 1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)     q <= RST_VAL;
    else if (en) q <= d;
  end

endmodule

// File: rtl/mcu_playlist_song_index_counter.sv
// Song index register that wraps in both directions over 0..NUM_SONGS-1.
// Wrapping is an explicit compare, so non-power-of-2 playlists wrap correctly.
module song_index_counter #(
  parameter int  NUM_SONGS = 4,
  localparam int SONG_W    = $clog2(NUM_SONGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              inc,
  input  logic              dec,
  output logic [SONG_W-1:0] song
);

  localparam logic [SONG_W-1:0] LAST = SONG_W'(NUM_SONGS - 1);

  logic [SONG_W-1:0] song_d;
  logic [SONG_W-1:0] song_q;
  logic              song_en;

  always_comb begin
    song_d  = song_q;
    song_en = clr | inc | dec;
    if (clr)      song_d = '0;
    else if (inc) song_d = (song_q == LAST) ? '0 : song_q + SONG_W'(1);
    else if (dec) song_d = (song_q == '0) ? LAST : song_q - SONG_W'(1);
  end

  dffre #(.W(SONG_W)) u_song_reg (
    .clk (clk),
    .rst (rst),
    .en  (song_en),
    .d   (song_d),
    .q   (song_q)
  );

  assign song = song_q;

endmodule

// File: rtl/mcu_playlist.sv
// Playlist control unit: sequences PAUSED/PLAYING/SWITCH over NUM_SONGS songs.
// Every output decodes from registers; button inputs never reach outputs combinationally.
module mcu_playlist
  import mcu_playlist_pkg::*;
#(
  parameter int  NUM_SONGS = 4,
  localparam int SONG_W    = $clog2(NUM_SONGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              play_button,
  input  logic              next_button,
  input  logic              prev_button,
  input  logic              mode_button,
  input  logic              song_done,
  output logic              play,
  output logic              reset_player,
  output logic [SONG_W-1:0] song,
  output logic [1:0]        mode,
  output logic              last_song
);

  localparam logic [SONG_W-1:0] LAST = SONG_W'(NUM_SONGS - 1);

  logic [1:0] state_d, state_q;
  logic [1:0] mode_d, mode_q;
  logic       resume_d, resume_q;
  logic       song_inc, song_dec, song_clr;
  logic [1:0] mode_eff;

  assign mode_eff = (mode_q == 2'd3) ? MODE_SINGLE : mode_q;

  always_comb begin
    state_d  = state_q;
    resume_d = resume_q;
    song_inc = 1'b0;
    song_dec = 1'b0;
    song_clr = 1'b0;
    mode_d   = mode_button ? next_mode(mode_q) : mode_q;
    case (state_q)
      PAUSED: begin
        if (play_button) begin
          state_d = PLAYING;
        end else if (next_button) begin
          song_inc = 1'b1;
          state_d  = SWITCH;
          resume_d = 1'b0;
        end else if (prev_button) begin
          song_dec = 1'b1;
          state_d  = SWITCH;
          resume_d = 1'b0;
        end
      end
      PLAYING: begin
        if (play_button) begin
          state_d = PAUSED;
        end else if (next_button) begin
          song_inc = 1'b1;
          state_d  = SWITCH;
          resume_d = 1'b1;
        end else if (prev_button) begin
          song_dec = 1'b1;
          state_d  = SWITCH;
          resume_d = 1'b1;
        end else if (song_done) begin
          state_d  = SWITCH;
          song_inc = (mode_eff != MODE_REPEAT_ONE);
          resume_d = (mode_eff != MODE_SINGLE);
        end
      end
      SWITCH: begin
        // A play press during the restart cycle flips where playback resumes.
        state_d = (resume_q ^ play_button) ? PLAYING : PAUSED;
      end
      default: begin
        state_d  = PAUSED;
        song_clr = 1'b1;
      end
    endcase
  end

  dffre #(.W(2), .RST_VAL(PAUSED)) u_state_reg (
    .clk (clk), .rst (reset), .en (1'b1), .d (state_d), .q (state_q)
  );

  dffre #(.W(2), .RST_VAL(MODE_SINGLE)) u_mode_reg (
    .clk (clk), .rst (reset), .en (1'b1), .d (mode_d), .q (mode_q)
  );

  dffre #(.W(1)) u_resume_reg (
    .clk (clk), .rst (reset), .en (1'b1), .d (resume_d), .q (resume_q)
  );

  song_index_counter #(.NUM_SONGS(NUM_SONGS)) u_song_cnt (
    .clk  (clk),
    .rst  (reset),
    .clr  (song_clr),
    .inc  (song_inc),
    .dec  (song_dec),
    .song (song)
  );

  assign play         = (state_q == PLAYING);
  assign reset_player = (state_q == SWITCH);
  assign mode         = mode_eff;
  assign last_song    = (song == LAST);

endmodule

// File: tb/tb_mcu_playlist.sv
// Bench for mcu_playlist: a 4-song and a 5-song instance share stimulus and are
// compared every cycle against a per-instance behavioural playlist model.
module tb_mcu_playlist;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic play_button = 1'b0, next_button = 1'b0, prev_button = 1'b0;
  logic mode_button = 1'b0, song_done = 1'b0;

  logic       play4, rp4, last4;
  logic [1:0] song4, mode4;
  logic       play5, rp5, last5;
  logic [2:0] song5;
  logic [1:0] mode5;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mcu_playlist #(.NUM_SONGS(4)) dut4 (
    .clk(clk), .reset(reset), .play_button(play_button), .next_button(next_button),
    .prev_button(prev_button), .mode_button(mode_button), .song_done(song_done),
    .play(play4), .reset_player(rp4), .song(song4), .mode(mode4), .last_song(last4)
  );

  mcu_playlist #(.NUM_SONGS(5)) dut5 (
    .clk(clk), .reset(reset), .play_button(play_button), .next_button(next_button),
    .prev_button(prev_button), .mode_button(mode_button), .song_done(song_done),
    .play(play5), .reset_player(rp5), .song(song5), .mode(mode5), .last_song(last5)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: "playing" is the listener-visible intent, "switching"
  // marks the one restart cycle, "dest" is whether playback continues after it.
  int  m_n[2] = '{4, 5};
  int  m_song[2];
  int  m_mode[2];
  bit  m_playing[2];
  bit  m_switching[2];
  bit  m_dest[2];

  always @(posedge clk or posedge reset) begin
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        m_song[k] = 0; m_mode[k] = 0; m_playing[k] = 0;
        m_switching[k] = 0; m_dest[k] = 0;
      end else begin
        if (m_switching[k]) begin
          m_switching[k] = 0;
          m_playing[k]   = m_dest[k] ^ play_button;
        end else if (play_button) begin
          m_playing[k] = !m_playing[k];
        end else if (next_button) begin
          m_song[k] = (m_song[k] + 1) % m_n[k];
          m_dest[k] = m_playing[k]; m_switching[k] = 1;
        end else if (prev_button) begin
          m_song[k] = (m_song[k] + m_n[k] - 1) % m_n[k];
          m_dest[k] = m_playing[k]; m_switching[k] = 1;
        end else if (m_playing[k] && song_done) begin
          if (m_mode[k] != 1) m_song[k] = (m_song[k] + 1) % m_n[k];
          m_dest[k] = (m_mode[k] != 0); m_switching[k] = 1;
        end
        if (mode_button) m_mode[k] = (m_mode[k] + 1) % 3;
      end
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      chk("play4",  play4, int'(m_playing[0] && !m_switching[0]));
      chk("rp4",    rp4,   int'(m_switching[0]));
      chk("song4",  song4, m_song[0]);
      chk("mode4",  mode4, m_mode[0]);
      chk("last4",  last4, int'(m_song[0] == 3));
      chk("play5",  play5, int'(m_playing[1] && !m_switching[1]));
      chk("rp5",    rp5,   int'(m_switching[1]));
      chk("song5",  song5, m_song[1]);
      chk("mode5",  mode5, m_mode[1]);
      chk("last5",  last5, int'(m_song[1] == 4));
    end
  end

  // Drive one cycle of button pulses; returns at the following negedge.
  task automatic cyc(input bit pb, input bit nb, input bit vb, input bit mb, input bit sd);
    play_button = pb; next_button = nb; prev_button = vb;
    mode_button = mb; song_done = sd;
    @(negedge clk);
    #1;
    play_button = 0; next_button = 0; prev_button = 0;
    mode_button = 0; song_done = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    chk("rst_play",  play4, 0);
    chk("rst_rp",    rp4,   0);
    chk("rst_song4", song4, 0);
    chk("rst_song5", song5, 0);
    chk("rst_mode",  mode4, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
  endtask

  task automatic mode_done(input int m, input int exp_song, input int exp_play);
    do_reset();
    for (int i = 0; i < m; i++) cyc(0, 0, 0, 1, 0);
    cyc(1, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    idle(1);
    chk("md_pre_song", song4, 1);
    chk("md_pre_play", play4, 1);
    cyc(0, 0, 0, 0, 1);
    chk("md_song", song4, exp_song);
    chk("md_rp",   rp4,   1);
    idle(1);
    chk("md_play", play4, exp_play);
  endtask

  initial begin
    @(negedge clk);
    #1;
    do_reset();

    cyc(1, 0, 0, 0, 0);
    chk("start_play", play4, 1);
    chk("start_song", song4, 0);
    chk("start_mode", mode4, 0);
    chk("start_rp",   rp4,   0);

    for (int i = 0; i < 3; i++) begin
      cyc(0, 1, 0, 0, 0);
      idle(1);
    end
    chk("at3_song", song4, 3);
    chk("at3_last", last4, 1);
    cyc(0, 1, 0, 0, 0);
    chk("wrap_song4", song4, 0);
    chk("wrap_rp",    rp4,   1);
    chk("wrap_play",  play4, 0);
    chk("wrap_song5", song5, 4);
    idle(1);
    chk("wrap_resume", play4, 1);

    cyc(1, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    idle(1);
    chk("p5_song0", song5, 0);
    cyc(0, 0, 1, 0, 0);
    chk("prev_song5", song5, 4);
    chk("prev_rp5",   rp5,   1);
    chk("prev_play5", play5, 0);
    idle(1);
    chk("prev_stay",  play5, 0);
    cyc(0, 0, 1, 0, 0);
    chk("prev2_song5", song5, 3);
    idle(1);

    mode_done(0, 2, 0);
    mode_done(1, 1, 1);
    mode_done(2, 2, 1);

    cyc(1, 1, 0, 0, 0);
    chk("pn_play", play4, 0);
    chk("pn_song", song4, 2);
    chk("pn_rp",   rp4,   0);

    cyc(1, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    chk("flip_play", play4, 0);
    chk("flip_rp",   rp4,   0);
    chk("flip_song", song4, 3);

    cyc(1, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    chk("sw_rp", rp4, 1);
    reset = 1'b1;
    #1;
    chk("swrst_song", song4, 0);
    chk("swrst_play", play4, 0);
    chk("swrst_rp",   rp4,   0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    idle(2);

    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
          $urandom_range(0, 9) == 0, $urandom_range(0, 5) == 0);
      if ($urandom_range(0, 499) == 0) do_reset();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
